// File: rtl/knight_pkg.sv
// Shared constants and types for the Knight robot command path.
// Opcodes, compass headings, UART response bytes and the tour FSM state encoding.
package knight_pkg;

    localparam logic [3:0] OP_CAL     = 4'h0;
    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_MOVE_FF = 4'h3;
    localparam logic [3:0] OP_TOUR    = 4'h4;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] ACK_DONE = 8'hA5;
    localparam logic [7:0] ACK_STEP = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        WAIT_V,
        HORZ,
        WAIT_H
    } tour_state_e;

    typedef struct packed {
        logic [7:0] hdg;
        logic [3:0] sq;
    } leg_t;

    function automatic logic [15:0] mk_cmd(input logic [3:0] op, input leg_t leg);
        return {op, leg.hdg, leg.sq};
    endfunction

endpackage

// File: rtl/tour_cmd_if.sv
// Command link between a command source and the command processor.
interface tour_cmd_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;

    modport master (output cmd, output cmd_rdy, input clr_cmd_rdy, input send_resp);
    modport slave  (input cmd, input cmd_rdy, output clr_cmd_rdy, output send_resp);
endinterface

// File: rtl/knight_move_decode.sv
// Maps a one-hot knight move to its vertical and horizontal legs (N/S first, then E/W).
module knight_move_decode
    import knight_pkg::*;
(
    input  logic [7:0] move,
    output leg_t       vert,
    output leg_t       horz
);

    always_comb begin
        vert = '{hdg: HDG_N, sq: 4'd0};
        horz = '{hdg: HDG_N, sq: 4'd0};
        case (move)
            8'h01: begin vert = '{hdg: HDG_N, sq: 4'd2}; horz = '{hdg: HDG_E, sq: 4'd1}; end
            8'h02: begin vert = '{hdg: HDG_N, sq: 4'd2}; horz = '{hdg: HDG_W, sq: 4'd1}; end
            8'h04: begin vert = '{hdg: HDG_N, sq: 4'd1}; horz = '{hdg: HDG_W, sq: 4'd2}; end
            8'h08: begin vert = '{hdg: HDG_S, sq: 4'd1}; horz = '{hdg: HDG_W, sq: 4'd2}; end
            8'h10: begin vert = '{hdg: HDG_S, sq: 4'd2}; horz = '{hdg: HDG_W, sq: 4'd1}; end
            8'h20: begin vert = '{hdg: HDG_S, sq: 4'd2}; horz = '{hdg: HDG_E, sq: 4'd1}; end
            8'h40: begin vert = '{hdg: HDG_S, sq: 4'd1}; horz = '{hdg: HDG_E, sq: 4'd2}; end
            8'h80: begin vert = '{hdg: HDG_N, sq: 4'd1}; horz = '{hdg: HDG_E, sq: 4'd2}; end
            default: ;
        endcase
    end

endmodule

// File: rtl/tour_cmd.sv
// Tour command source: passes UART commands through in IDLE, otherwise plays
// back the solved tour as vertical/horizontal move command pairs.
module tour_cmd
    import knight_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    tour_cmd_if.master  cp,
    output logic [7:0]  resp
);

    tour_state_e state_q, state_d;
    logic [4:0]  mv_indx_q, mv_indx_d;
    logic [7:0]  move_q, move_d;
    logic [1:0]  settle_q, settle_d;

    leg_t vert_leg, horz_leg;
    logic last_move;
    logic vert_ready;

    knight_move_decode u_decode (
        .move (move_q),
        .vert (vert_leg),
        .horz (horz_leg)
    );

    assign last_move  = (mv_indx_q == 5'(NUM_MOVES - 1));
    // settle_q: 0 = index just changed, 1 = move captured, 2 = command presented
    assign vert_ready = (settle_q == 2'd2);
    assign mv_indx    = mv_indx_q;

    always_comb begin
        state_d   = state_q;
        mv_indx_d = mv_indx_q;
        move_d    = move_q;
        settle_d  = settle_q;
        case (state_q)
            IDLE: begin
                if (start_tour) begin
                    state_d   = VERT;
                    mv_indx_d = '0;
                    settle_d  = '0;
                end
            end
            VERT: begin
                if (settle_q == 2'd0) move_d = move;
                if (!vert_ready)      settle_d = settle_q + 2'd1;
                else if (cp.clr_cmd_rdy) state_d = WAIT_V;
            end
            WAIT_V: begin
                if (cp.send_resp) state_d = HORZ;
            end
            HORZ: begin
                if (cp.clr_cmd_rdy) state_d = WAIT_H;
            end
            WAIT_H: begin
                if (cp.send_resp) begin
                    if (last_move) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = VERT;
                        mv_indx_d = mv_indx_q + 5'd1;
                        settle_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mv_indx_q <= '0;
            move_q    <= '0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
            move_q    <= move_d;
            settle_q  <= settle_d;
        end
    end

    always_comb begin
        cp.cmd           = mk_cmd(OP_MOVE, vert_leg);
        cp.cmd_rdy       = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = ACK_STEP;
        case (state_q)
            IDLE: begin
                cp.cmd           = cmd_UART;
                cp.cmd_rdy       = cmd_rdy_UART;
                // a tour start in the same cycle leaves the host command pending
                clr_cmd_rdy_UART = cp.clr_cmd_rdy & ~start_tour;
                resp             = ACK_DONE;
            end
            VERT:   cp.cmd_rdy = vert_ready;
            WAIT_V: ;
            HORZ: begin
                cp.cmd     = mk_cmd(OP_MOVE_FF, horz_leg);
                cp.cmd_rdy = 1'b1;
            end
            WAIT_H: begin
                cp.cmd = mk_cmd(OP_MOVE_FF, horz_leg);
                if (last_move) resp = ACK_DONE;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Directed self-checking bench for tour_cmd: pass-through, single moves, full tour,
// hold-off, simultaneous events, move latching and reset mid-tour.
module tb_tour_cmd;

    logic        clk;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [7:0]  resp;

    logic [7:0]  mem [0:31];
    int          n_asserts;
    int          n_fail;
    int          n_cmds;

    tour_cmd_if cpif ();

    tour_cmd #(.NUM_MOVES(24)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cp               (cpif),
        .resp             (resp)
    );

    assign move = mem[mv_indx];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tour-mode command acceptances (host acknowledge held low)
    always @(posedge clk)
        if (cpif.cmd_rdy && cpif.clr_cmd_rdy && !clr_cmd_rdy_UART) n_cmds++;

    function automatic logic [15:0] exp_vert(input logic [7:0] m);
        case (m)
            8'h01: return 16'h2002;
            8'h02: return 16'h2002;
            8'h04: return 16'h2001;
            8'h08: return 16'h27F1;
            8'h10: return 16'h27F2;
            8'h20: return 16'h27F2;
            8'h40: return 16'h27F1;
            8'h80: return 16'h2001;
            default: return 16'h2000;
        endcase
    endfunction

    function automatic logic [15:0] exp_horz(input logic [7:0] m);
        case (m)
            8'h01: return 16'h3BF1;
            8'h02: return 16'h33F1;
            8'h04: return 16'h33F2;
            8'h08: return 16'h33F2;
            8'h10: return 16'h33F1;
            8'h20: return 16'h3BF1;
            8'h40: return 16'h3BF2;
            8'h80: return 16'h3BF2;
            default: return 16'h3000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit collide);
        start_tour = 1'b1;
        if (collide) begin
            cmd_rdy_UART     = 1'b1;
            cpif.clr_cmd_rdy = 1'b1;
            #1 check("start_vs_uart_ack", 16'(clr_cmd_rdy_UART), 16'h0);
        end
        tick();
        start_tour       = 1'b0;
        cpif.clr_cmd_rdy = 1'b0;
        if (collide) cmd_rdy_UART = 1'b0;
    endtask

    // Entered just after the edge into VERT; leaves just after the edge out of WAIT_H
    task automatic step(input logic [4:0] idx, input logic [7:0] m, input bit last,
                        input bit both, input bit abort);
        logic [15:0] ev;
        logic [15:0] eh;
        logic [7:0]  saved;
        ev = exp_vert(m);
        eh = exp_horz(m);
        check("mv_indx", 16'(mv_indx), 16'(idx));
        check("settle0_rdy", 16'(cpif.cmd_rdy), 16'h0);
        tick();
        check("settle1_rdy", 16'(cpif.cmd_rdy), 16'h0);
        tick();
        check("vert_rdy", 16'(cpif.cmd_rdy), 16'h1);
        check("vert_cmd", cpif.cmd, ev);
        check("vert_resp", 16'(resp), 16'h5A);
        cpif.clr_cmd_rdy = 1'b1;
        cpif.send_resp   = both;
        #1 check("holdoff_ack", 16'(clr_cmd_rdy_UART), 16'h0);
        tick();
        cpif.clr_cmd_rdy = 1'b0;
        cpif.send_resp   = 1'b0;
        saved    = mem[idx];
        mem[idx] = 8'h00;
        #1 check("waitv_rdy", 16'(cpif.cmd_rdy), 16'h0);
        check("waitv_resp", 16'(resp), 16'h5A);
        if (both) begin
            tick();
            check("simul_send_dropped", cpif.cmd, ev);
        end
        start_tour     = 1'b1;
        cpif.send_resp = 1'b1;
        tick();
        start_tour     = 1'b0;
        cpif.send_resp = 1'b0;
        #1 check("horz_cmd", cpif.cmd, eh);
        check("horz_rdy", 16'(cpif.cmd_rdy), 16'h1);
        mem[idx] = saved;
        cpif.clr_cmd_rdy = 1'b1;
        tick();
        cpif.clr_cmd_rdy = 1'b0;
        #1 check("waith_rdy", 16'(cpif.cmd_rdy), 16'h0);
        check("waith_resp", 16'(resp), last ? 16'h00A5 : 16'h005A);
        check("waith_idx", 16'(mv_indx), 16'(idx));
        if (abort) begin
            rst_n = 1'b0;
            #1 check("rst_idx", 16'(mv_indx), 16'h0);
            check("rst_resp", 16'(resp), 16'hA5);
            check("rst_rdy", 16'(cpif.cmd_rdy), 16'(cmd_rdy_UART));
            tick();
            rst_n = 1'b1;
            tick();
        end else begin
            cpif.send_resp = 1'b1;
            tick();
            cpif.send_resp = 1'b0;
            #1;
        end
    endtask

    initial begin
        n_asserts        = 0;
        n_fail           = 0;
        n_cmds           = 0;
        rst_n            = 1'b0;
        start_tour       = 1'b0;
        cmd_UART         = 16'h1234;
        cmd_rdy_UART     = 1'b0;
        cpif.clr_cmd_rdy = 1'b0;
        cpif.send_resp   = 1'b0;
        for (int unsigned i = 0; i < 32; i++) mem[i] = 8'h01;

        #2;
        check("reset_idx", 16'(mv_indx), 16'h0);
        check("reset_cmd", cpif.cmd, 16'h1234);
        check("reset_rdy", 16'(cpif.cmd_rdy), 16'h0);
        check("reset_resp", 16'(resp), 16'hA5);
        check("reset_ack", 16'(clr_cmd_rdy_UART), 16'h0);
        #10 rst_n = 1'b1;
        tick();

        // IDLE pass-through
        cmd_UART     = 16'h0000;
        cmd_rdy_UART = 1'b1;
        #1 check("pt_cmd", cpif.cmd, 16'h0000);
        check("pt_rdy", 16'(cpif.cmd_rdy), 16'h1);
        cpif.clr_cmd_rdy = 1'b1;
        #1 check("pt_ack", 16'(clr_cmd_rdy_UART), 16'h1);
        cmd_UART = 16'hBEEF;
        #1 check("pt_cmd2", cpif.cmd, 16'hBEEF);
        check("pt_resp", 16'(resp), 16'hA5);
        cpif.clr_cmd_rdy = 1'b0;
        cmd_rdy_UART     = 1'b0;
        #1 check("pt_ack_low", 16'(clr_cmd_rdy_UART), 16'h0);
        tick();

        // Single move bit 0, aborted at WAIT_H
        start(1'b0);
        step(5'd0, 8'h01, 1'b0, 1'b0, 1'b1);

        // Single move bit 3, started alongside a host command
        mem[0] = 8'h08;
        start(1'b1);
        step(5'd0, 8'h08, 1'b0, 1'b0, 1'b1);

        // Full tour with a host command pending throughout
        for (int unsigned i = 0; i < 32; i++) mem[i] = 8'h01 << (i % 8);
        mem[13]      = 8'h05;
        cmd_UART     = 16'h4123;
        cmd_rdy_UART = 1'b1;
        n_cmds       = 0;
        start(1'b0);
        for (int unsigned i = 0; i < 24; i++)
            step(5'(i), mem[i], i == 23, i == 4, 1'b0);
        check("tour_cmd_count", 16'(n_cmds), 16'd48);
        check("post_tour_cmd", cpif.cmd, 16'h4123);
        check("post_tour_rdy", 16'(cpif.cmd_rdy), 16'h1);
        check("post_tour_resp", 16'(resp), 16'hA5);
        cpif.clr_cmd_rdy = 1'b1;
        #1 check("post_tour_ack", 16'(clr_cmd_rdy_UART), 16'h1);
        cpif.clr_cmd_rdy = 1'b0;
        cmd_rdy_UART     = 1'b0;
        tick();

        // Reset in WAIT_H at mv_indx 7
        start(1'b0);
        for (int unsigned i = 0; i < 7; i++)
            step(5'(i), mem[i], 1'b0, 1'b0, 1'b0);
        step(5'd7, mem[7], 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        cmd_UART = 16'h2468;
        #1 check("after_rst_idx", 16'(mv_indx), 16'h0);
        check("after_rst_cmd", cpif.cmd, 16'h2468);
        check("after_rst_rdy", 16'(cpif.cmd_rdy), 16'h0);
        check("after_rst_resp", 16'(resp), 16'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/tour_cmd.md
# tour_cmd

Command source for the Knight robot's command processor, converting a solved knight's tour into robot move commands. In idle it passes UART host commands straight through to the command processor. Once the tour solver pulses `start_tour`, it takes over the command interface. For each tour step it reads the one-hot knight move at `mv_indx` and issues two move commands: a vertical leg, then a horizontal leg with fanfare. It sits between the UART wrapper, the tour solver's move memory, and the command processor.

## Interface
- `NUM_MOVES`, default 24: number of tour moves (5x5 board, 25 squares).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_tour` in 1: one-cycle pulse from the solver; the tour is solved and the move memory is valid.
- `move` in 8: one-hot knight move read at `mv_indx`; valid the cycle after `mv_indx` changes.
- `mv_indx` out 5: move-memory address.
- `cmd_UART` in 16: host command.
- `cmd_rdy_UART` in 1: host command valid.
- `clr_cmd_rdy_UART` out 1: acknowledges the host command.
- `cmd` out 16: command to the command processor.
  - [15:12] opcode: 0010 move, 0011 move with fanfare.
  - [11:4] heading.
  - [3:0] squares.
- `cmd_rdy` out 1: command valid to the command processor.
- `clr_cmd_rdy` in 1: command processor has taken `cmd`.
- `send_resp` in 1: command processor has completed a command.
- `resp` out 8: response byte to the UART; 8'hA5 means done, 8'h5A means tour step acknowledged.

## Operation
- **Headings:** north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
- **Move decode:** north is +y, east is +x. Vertical leg first, horizontal leg second.

| `move` bit | dx | dy | Vertical leg | Horizontal leg |
|---|---|---|---|---|
| 0 | +1 | +2 | N 2 | E 1 |
| 1 | -1 | +2 | N 2 | W 1 |
| 2 | -2 | +1 | N 1 | W 2 |
| 3 | -2 | -1 | S 1 | W 2 |
| 4 | -1 | -2 | S 2 | W 1 |
| 5 | +1 | -2 | S 2 | E 1 |
| 6 | +2 | -1 | S 1 | E 2 |
| 7 | +2 | +1 | N 1 | E 2 |

- **Opcodes and fields:**
  - Vertical command: `{4'b0010, heading, squares}`.
  - Horizontal command: `{4'b0011, heading, squares}`.
  - Non-one-hot `move`: both legs use heading 8'h00 and 0 squares.
- **FSM states:** IDLE, VERT, WAIT_V, HORZ, WAIT_H.
  - IDLE: pass-through. `cmd=cmd_UART`, `cmd_rdy=cmd_rdy_UART`, `clr_cmd_rdy_UART=clr_cmd_rdy`, `resp=8'hA5`. On `start_tour`: clear `mv_indx` to 0 and go to VERT.
  - VERT: drive the vertical command with `cmd_rdy=1`. On `clr_cmd_rdy`, go to WAIT_V.
  - WAIT_V: `cmd_rdy=0`. On `send_resp`, go to HORZ.
  - HORZ: drive the horizontal command with `cmd_rdy=1`. On `clr_cmd_rdy`, go to WAIT_H.
  - WAIT_H: on `send_resp`:
    - if `mv_indx==NUM_MOVES-1`, go to IDLE;
    - otherwise increment `mv_indx` and go to VERT.
- **Tour-mode signals (all non-IDLE states):**
  - `clr_cmd_rdy_UART=0`; host commands are held off.
  - `resp=8'h5A`, except in WAIT_H when `mv_indx==NUM_MOVES-1`, where `resp=8'hA5`.
- **Move latch:** `move` is registered into a local move register on entry to VERT, so the horizontal leg uses the same move even if memory changes.
- **Ignored inputs:** `start_tour` is ignored outside IDLE. `cmd_rdy_UART` is ignored outside IDLE; it stays pending and is serviced after returning to IDLE.

## Timing
- **Reset values:**
  - State IDLE, `mv_indx=0`, move register 0.
  - Outputs follow IDLE pass-through: `cmd_rdy=cmd_rdy_UART`, `resp=8'hA5`.
- **Move load:**
  - `mv_indx` updates on the clock edge that enters VERT.
  - The move register captures `move` one cycle later.
  - VERT asserts `cmd_rdy` only from the cycle after the capture. This gives a 2-cycle settle from index change to `cmd_rdy`.
- **Combinational paths:** `cmd` and `cmd_rdy` are combinational from state and the move register. The IDLE pass-through is purely combinational, with zero latency.
- **Handshake:** `cmd_rdy` stays high until the cycle `clr_cmd_rdy` is sampled. It deasserts the next cycle.
- **Simultaneous events:**
  - `clr_cmd_rdy` and `send_resp` in the same cycle while in VERT/HORZ: take `clr_cmd_rdy` only; `send_resp` is not stored.
  - `start_tour` together with `cmd_rdy_UART` in IDLE: the tour wins, and the UART command is not acknowledged.
- **Reset mid-tour:** immediate return to IDLE with `mv_indx=0`. The tour does not resume.

## Structure
- **Shared package `knight_pkg`:**
  - Opcode constants (CAL 4'h0, MOVE 4'h2, MOVE_FF 4'h3, TOUR 4'h4).
  - Heading constants (N, W, S, E).
  - Response constants (ACK_DONE 8'hA5, ACK_STEP 8'h5A).
  - State enum.
- **Sub-module `knight_move_decode`:** combinational. Maps one-hot `move` to {vert heading, vert squares, horz heading, horz squares}.

## Test plan
- **IDLE pass-through:**
  - `cmd_UART=16'h0000`, `cmd_rdy_UART=1` gives `cmd=16'h0000`, `cmd_rdy=1` in the same cycle.
  - `clr_cmd_rdy=1` gives `clr_cmd_rdy_UART=1`.
  - `resp=8'hA5` throughout.
- **Single move, bit 0:** `move=8'h01` with `start_tour`:
  - first command is `16'h2002`, second is `16'h3BF1`;
  - `resp=8'h5A` after the first `send_resp`.
- **Single move, bit 3:** `move=8'h08` gives commands `16'h27F1` then `16'h33F2`.
- **Full tour, `NUM_MOVES=24`:**
  - 48 commands are issued;
  - `mv_indx` steps 0 to 23;
  - `resp=8'hA5` on the final `send_resp`;
  - the FSM returns to IDLE.
- **Hold-off:** `cmd_rdy_UART=1` during the tour gives `clr_cmd_rdy_UART=0` until IDLE, then the command passes through.
- **Reset mid-tour:** assert `rst_n=0` in WAIT_H at `mv_indx=7`. Then `mv_indx=0` and IDLE pass-through resumes.
